// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall against an EX/MEM/WB write scoreboard plus branch flush.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_addr,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ir_en,
  output logic             npc_en,
  output logic             id_bubble,
  output logic             if_flush,
  output logic [1:0]       hz_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned AW = 5;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ex_wen_q, mem_wen_q, wb_wen_q;
  logic [AW-1:0] ex_waddr_q, mem_waddr_q, wb_waddr_q;
  logic          new_wen;
  logic [AW-1:0] new_waddr;
  logic          rs_hit, rt_hit, raw_hz;

  // Source matches a pending write in any of EX/MEM/WB; $0 never hazards.
  always_comb begin
    rs_hit = id_uses_rs && (id_rs_addr != '0) &&
             ((ex_wen_q  && (ex_waddr_q  == id_rs_addr)) ||
              (mem_wen_q && (mem_waddr_q == id_rs_addr)) ||
              (wb_wen_q  && (wb_waddr_q  == id_rs_addr)));
    rt_hit = id_uses_rt && (id_rt_addr != '0) &&
             ((ex_wen_q  && (ex_waddr_q  == id_rt_addr)) ||
              (mem_wen_q && (mem_waddr_q == id_rt_addr)) ||
              (wb_wen_q  && (wb_waddr_q  == id_rt_addr)));
    raw_hz = id_valid && (rs_hit || rt_hit);
  end

  // Next state and pipeline controls; branch beats RAW stall beats normal flow.
  always_comb begin
    state_d   = ST_RUN;
    pc_en     = 1'b1;
    ir_en     = 1'b1;
    npc_en    = 1'b1;
    id_bubble = 1'b0;
    if_flush  = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (ex_branch_taken) begin
          if_flush  = 1'b1;
          id_bubble = 1'b1;
          state_d   = ST_FLUSH;
        end else if (raw_hz) begin
          pc_en     = 1'b0;
          ir_en     = 1'b0;
          npc_en    = 1'b0;
          id_bubble = 1'b1;
          state_d   = ST_STALL;
        end
      end
      ST_FLUSH: begin
        if_flush  = 1'b1;
        id_bubble = 1'b1;
        if (ex_branch_taken) begin
          state_d = ST_FLUSH;
        end else if (raw_hz) begin
          state_d = ST_STALL;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Reset forces the RUN view of the controls without waiting for a clock.
    if (!rst_n) begin
      state_d   = ST_RUN;
      pc_en     = 1'b1;
      ir_en     = 1'b1;
      npc_en    = 1'b1;
      id_bubble = 1'b0;
      if_flush  = 1'b0;
    end
  end

  assign new_wen   = id_valid && id_wr_en && !id_bubble;
  assign new_waddr = id_bubble ? AW'(0) : id_wr_addr;
  assign hz_state  = state_q;

  // State register and write scoreboard shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ex_wen_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      wb_wen_q    <= 1'b0;
      ex_waddr_q  <= '0;
      mem_waddr_q <= '0;
      wb_waddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ex_wen_q    <= new_wen;
      ex_waddr_q  <= new_waddr;
      mem_wen_q   <= ex_wen_q;
      mem_waddr_q <= ex_waddr_q;
      wb_wen_q    <= mem_wen_q;
      wb_waddr_q  <= mem_waddr_q;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc;

  assign stall_inc = raw_hz && !ex_branch_taken;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (if_flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected control vectors are queued per cycle and checked at negedge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs_addr, id_rt_addr, id_wr_addr;
  logic       id_uses_rs, id_uses_rt, id_wr_en;
  logic       ex_branch_taken;
  logic       pc_en, ir_en, npc_en, id_bubble, if_flush;
  logic [1:0] hz_state;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ir_en(ir_en), .npc_en(npc_en),
    .id_bubble(id_bubble), .if_flush(if_flush), .hz_state(hz_state)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // {pc_en, ir_en, npc_en, id_bubble, if_flush, hz_state}
  localparam logic [6:0] RUN0 = 7'b1110000;
  localparam logic [6:0] RUN1 = 7'b1110001;
  localparam logic [6:0] STL0 = 7'b0001000;
  localparam logic [6:0] STL1 = 7'b0001001;
  localparam logic [6:0] FLS0 = 7'b1111100;
  localparam logic [6:0] FLS2 = 7'b1111110;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drv(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic wen, input logic [4:0] wa, input logic br);
    id_valid = v; id_rs_addr = rs; id_uses_rs = urs;
    id_rt_addr = rt; id_uses_rt = urt;
    id_wr_en = wen; id_wr_addr = wa; ex_branch_taken = br;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a);
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic rd_rs(input logic [4:0] a, input logic br);
    drv(1'b1, a, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, br);
  endtask

  task automatic push(input string tag, input logic [6:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic chk();
    exp_t       x;
    logic [6:0] obs;
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got no entry want one");
    end else begin
      x   = q.pop_front();
      obs = {pc_en, ir_en, npc_en, id_bubble, if_flush, hz_state};
      assert (obs === x.exp) else begin
        bad++;
        $error("FAIL %s: got %b want %b", x.tag, obs, x.exp);
      end
    end
  endtask

  // One clock: queue expectation, sample at negedge, return just after next posedge.
  task automatic cyc(input string tag, input logic [6:0] e);
    push(tag, e);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
  endtask

  task automatic cchk(input string tag, input logic [15:0] obs, input logic [15:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    push("reset_branch_masked", RUN0);
    @(negedge clk);
    chk();
    idle();
    @(posedge clk);
    #1;
    cyc("reset_idle", RUN0);
    rst_n = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    cchk("reset_stall_cnt", stall_cnt, 16'd0);
    cchk("reset_flush_cnt", flush_cnt, 16'd0);
`endif

    // Back-to-back dependency: three stall cycles.
    wr(5'd5);          cyc("a_write5", RUN0);
    rd_rs(5'd5, 1'b0); cyc("a_stall_ex", STL0);
                       cyc("a_stall_mem", STL1);
                       cyc("a_stall_wb", STL1);
                       cyc("a_release", RUN1);
    idle();            cyc("a_idle", RUN0);
`ifdef HAZ_PERF_CNT_EN
    cchk("a_stall_cnt", stall_cnt, 16'd3);
`endif

    // One instruction apart on rt: two stall cycles.
    wr(5'd5);          cyc("b_write5", RUN0);
    wr(5'd7);          cyc("b_unrelated", RUN0);
    drv(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
                       cyc("b_stall_mem", STL0);
                       cyc("b_stall_wb", STL1);
                       cyc("b_release", RUN1);
    idle();            cyc("b_idle", RUN0);
`ifdef HAZ_PERF_CNT_EN
    cchk("b_stall_cnt", stall_cnt, 16'd5);
`endif

    // Invalid ID instruction never stalls.
    wr(5'd5);          cyc("v_write5", RUN0);
    drv(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
                       cyc("v_invalid_read", RUN0);
    idle();            cyc("v_idle", RUN0);

    // Register zero never stalls.
    wr(5'd0);          cyc("c_write0", RUN0);
    rd_rs(5'd0, 1'b0); cyc("c_read0", RUN0);
    idle();            cyc("c_idle", RUN0);

    // Branch overrides a live RAW hazard.
    wr(5'd5);          cyc("d_write5", RUN0);
    rd_rs(5'd5, 1'b1); cyc("d_branch_over_raw", FLS0);
    idle();            cyc("d_flush", FLS2);
                       cyc("d_back_run", RUN0);
`ifdef HAZ_PERF_CNT_EN
    cchk("d_flush_cnt", flush_cnt, 16'd2);
    cchk("d_stall_cnt", stall_cnt, 16'd5);
`endif

    // FLUSH exits into STALL when the hazard is still live.
    wr(5'd6);          cyc("e_write6", RUN0);
    rd_rs(5'd6, 1'b1); cyc("e_branch", FLS0);
    rd_rs(5'd6, 1'b0); cyc("e_flush_raw", FLS2);
                       cyc("e_stall_wb", STL1);
                       cyc("e_release", RUN1);
    idle();            cyc("e_idle", RUN0);
`ifdef HAZ_PERF_CNT_EN
    cchk("e_flush_cnt", flush_cnt, 16'd4);
    cchk("e_stall_cnt", stall_cnt, 16'd7);
`endif

    // Reset in the second stall cycle abandons the stall at once.
    wr(5'd5);          cyc("f_write5", RUN0);
    rd_rs(5'd5, 1'b0); cyc("f_stall1", STL0);
    push("f_stall2", STL1);
    @(negedge clk);
    chk();
    #1;
    rst_n = 1'b0;
    #1;
    push("f_reset_now", RUN0);
    chk();
`ifdef HAZ_PERF_CNT_EN
    cchk("f_reset_stall_cnt", stall_cnt, 16'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("f_read5_after", RUN0);
    idle();            cyc("f_idle", RUN0);

    // Stall counter saturates.
`ifdef HAZ_PERF_CNT_EN
    force dut.stall_q = 16'hFFFE;
    #1;
    release dut.stall_q;
`endif
    wr(5'd5);          cyc("g_write5", RUN0);
    rd_rs(5'd5, 1'b0); cyc("g_stall1", STL0);
`ifdef HAZ_PERF_CNT_EN
    cchk("g_cnt_top", stall_cnt, 16'hFFFF);
`endif
                       cyc("g_stall2", STL1);
                       cyc("g_stall3", STL1);
                       cyc("g_release", RUN1);
    idle();            cyc("g_idle", RUN0);
`ifdef HAZ_PERF_CNT_EN
    cchk("g_cnt_sat", stall_cnt, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
